// File: rtl/dmem_arbiter.sv
// Round-robin arbiter that lets two requesters share one byte-wide synchronous data memory,
// splitting each 1/2/4-byte access into little-endian single-byte beats.
module dmem_arbiter #(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 a_req,
    input  logic                 a_we,
    input  logic [1:0]           a_size,
    input  logic [ADDR_BITS-1:0] a_addr,
    input  logic [31:0]          a_wdata,
    output logic                 a_done,
    output logic [31:0]          a_rdata,
    input  logic                 b_req,
    input  logic                 b_we,
    input  logic [1:0]           b_size,
    input  logic [ADDR_BITS-1:0] b_addr,
    input  logic [31:0]          b_wdata,
    output logic                 b_done,
    output logic [31:0]          b_rdata,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [7:0]           mem_wdata,
    input  logic [7:0]           mem_rdata,
    output logic [1:0]           dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                 state_q;
    logic                   last_b_q;
    logic                   port_q;
    logic                   we_q;
    logic [1:0]             last_beat_q;
    logic [1:0]             beat_q;
    logic [ADDR_BITS-1:0]   addr_q;
    logic [31:0]            wdata_q;
    logic [31:0]            rbuf_q;
    logic                   a_done_q, b_done_q;
    logic [31:0]            a_rdata_q, b_rdata_q;
    logic                   mem_en_q, mem_we_q;
    logic [ADDR_BITS-1:0]   mem_addr_q;
    logic [7:0]             mem_wdata_q;

    logic                   grant_b;
    logic                   sel_we;
    logic [1:0]             sel_size;
    logic [ADDR_BITS-1:0]   sel_addr;
    logic [31:0]            sel_wdata;
    logic [1:0]             sel_last_beat;
    logic [1:0]             beat_nx;
    logic [31:0]            cap_xfer;
    logic [31:0]            cap_drain;

    // On a tie the port that did not win last time gets the memory.
    assign grant_b   = b_req && (!a_req || !last_b_q);
    assign sel_we    = grant_b ? b_we    : a_we;
    assign sel_size  = grant_b ? b_size  : a_size;
    assign sel_addr  = grant_b ? b_addr  : a_addr;
    assign sel_wdata = grant_b ? b_wdata : a_wdata;

    always_comb begin
        sel_last_beat = 2'd3;
        if (sel_size == 2'b00)      sel_last_beat = 2'd0;
        else if (sel_size == 2'b01) sel_last_beat = 2'd1;
    end

    // The byte arriving now belongs to the beat issued one cycle earlier.
    assign beat_nx   = beat_q + 2'd1;
    assign cap_xfer  = rbuf_q | ({24'd0, mem_rdata} << {beat_q - 2'd1, 3'b000});
    assign cap_drain = rbuf_q | ({24'd0, mem_rdata} << {last_beat_q, 3'b000});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            last_b_q    <= 1'b1;
            port_q      <= 1'b0;
            we_q        <= 1'b0;
            last_beat_q <= 2'd0;
            beat_q      <= 2'd0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rbuf_q      <= '0;
            a_done_q    <= 1'b0;
            b_done_q    <= 1'b0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            a_done_q <= 1'b0;
            b_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (a_req || b_req) begin
                        port_q      <= grant_b;
                        last_b_q    <= grant_b;
                        we_q        <= sel_we;
                        last_beat_q <= sel_last_beat;
                        addr_q      <= sel_addr;
                        wdata_q     <= sel_wdata;
                        beat_q      <= 2'd0;
                        rbuf_q      <= '0;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= sel_we;
                        mem_addr_q  <= sel_addr;
                        mem_wdata_q <= sel_wdata[7:0];
                        state_q     <= XFER;
                    end
                end
                XFER: begin
                    if (beat_q != 2'd0 && !we_q) rbuf_q <= cap_xfer;
                    if (beat_q == last_beat_q) begin
                        mem_en_q <= 1'b0;
                        mem_we_q <= 1'b0;
                        state_q  <= DRAIN;
                    end else begin
                        beat_q      <= beat_nx;
                        mem_addr_q  <= addr_q + ADDR_BITS'(beat_nx);
                        mem_wdata_q <= wdata_q[{beat_nx, 3'b000} +: 8];
                    end
                end
                DRAIN: begin
                    if (port_q) begin
                        b_done_q  <= 1'b1;
                        b_rdata_q <= we_q ? 32'd0 : cap_drain;
                    end else begin
                        a_done_q  <= 1'b1;
                        a_rdata_q <= we_q ? 32'd0 : cap_drain;
                    end
                    state_q <= RESP;
                end
                RESP: begin
                    beat_q  <= 2'd0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign a_done      = a_done_q;
    assign b_done      = b_done_q;
    assign a_rdata     = a_rdata_q;
    assign b_rdata     = b_rdata_q;
    assign mem_en      = mem_en_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a behavioural 1-cycle-latency byte memory plus
// one task per scenario with hand-computed expectations.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_req, a_we, b_req, b_we;
    logic [1:0]  a_size, b_size;
    logic [9:0]  a_addr, b_addr;
    logic [31:0] a_wdata, b_wdata;
    logic        a_done, b_done;
    logic [31:0] a_rdata, b_rdata;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'd0;
    logic [1:0]  dbg_state;

    logic [7:0]  mem_model [1024];

    int checks = 0;
    int failures = 0;

    dmem_arbiter #(.ADDR_BITS(10)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_size(a_size), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_done(a_done), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_size(b_size), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_done(b_done), .b_rdata(b_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem_model[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem_model[mem_addr];
        end
    end

    // One access on one port; cycles counts from the accepting IDLE cycle through the done cycle.
    task automatic access(input bit port, input logic we, input logic [1:0] size,
                          input logic [9:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output int cycles, output int en_cnt,
                          output bit other_done);
        int edges;
        @(negedge clk);
        if (port) begin
            b_req = 1; b_we = we; b_size = size; b_addr = addr; b_wdata = wd;
        end else begin
            a_req = 1; a_we = we; a_size = size; a_addr = addr; a_wdata = wd;
        end
        @(posedge clk); #1;
        a_req = 0; b_req = 0;
        a_addr = ~addr; b_addr = ~addr; a_wdata = ~wd; b_wdata = ~wd;
        a_we = ~we; b_we = ~we; a_size = 2'b00; b_size = 2'b00;
        edges = 1;
        en_cnt = int'(mem_en);
        other_done = 0;
        while (!(port ? b_done : a_done) && edges < 20) begin
            @(posedge clk); #1;
            edges++;
            en_cnt += int'(mem_en);
            if (port ? a_done : b_done) other_done = 1;
        end
        cycles = (port ? b_done : a_done) ? edges + 1 : -1;
        rd = port ? b_rdata : a_rdata;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        int en_seen;
        int edges;
        en_seen = 0;
        rst = 0;
        a_req = 1; b_req = 1; a_we = 0; b_we = 0; a_size = 0; b_size = 0;
        a_addr = 10'h000; b_addr = 10'h001; a_wdata = 0; b_wdata = 0;
        repeat (5) begin
            @(negedge clk);
            en_seen += int'(mem_en);
        end
        checks++;
        if (en_seen !== 0) begin
            failures++; $display("FAIL reset_mem_en: saw %0d high cycles, want 0", en_seen);
        end
        checks++;
        if ({a_done, b_done, a_rdata, b_rdata, mem_we, mem_addr, mem_wdata, dbg_state} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: a_done=%b b_done=%b a_rdata=%h b_rdata=%h we=%b addr=%h wd=%h st=%0d, want all 0",
                     a_done, b_done, a_rdata, b_rdata, mem_we, mem_addr, mem_wdata, dbg_state);
        end
        rst = 1;
        @(posedge clk); #1;
        a_req = 0; b_req = 0;
        edges = 1;
        while (!a_done && !b_done && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
        checks++;
        if (!(a_done === 1'b1 && b_done === 1'b0)) begin
            failures++; $display("FAIL reset_first_grant: a_done=%b b_done=%b, want A first", a_done, b_done);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_word_a();
        logic [31:0] rd;
        int cyc, en;
        bit od;
        access(0, 1, 2'b10, 10'h010, 32'hDEADBEEF, rd, cyc, en, od);
        checks++;
        if (cyc !== 7 || en !== 4 || od) begin
            failures++; $display("FAIL word_write_timing: cycles=%0d en=%0d other=%b, want 7 4 0", cyc, en, od);
        end
        checks++;
        if (rd !== 32'd0) begin
            failures++; $display("FAIL word_write_rdata: got %h want 00000000", rd);
        end
        checks++;
        if ({mem_model[10'h013], mem_model[10'h012], mem_model[10'h011], mem_model[10'h010]} !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL word_write_bytes: got %h %h %h %h want EF BE AD DE",
                     mem_model[10'h010], mem_model[10'h011], mem_model[10'h012], mem_model[10'h013]);
        end
        access(0, 0, 2'b10, 10'h010, 32'h0, rd, cyc, en, od);
        checks++;
        if (rd !== 32'hDEADBEEF || cyc !== 7) begin
            failures++; $display("FAIL word_read: got %h in %0d cycles want DEADBEEF in 7", rd, cyc);
        end
        access(0, 0, 2'b11, 10'h010, 32'h0, rd, cyc, en, od);
        checks++;
        if (rd !== 32'hDEADBEEF || cyc !== 7 || en !== 4) begin
            failures++; $display("FAIL size11_read: got %h cycles=%0d en=%0d want DEADBEEF 7 4", rd, cyc, en);
        end
    endtask

    task automatic test_sizes_b();
        logic [31:0] rd;
        int cyc, en;
        bit od;
        access(1, 0, 2'b00, 10'h012, 32'h0, rd, cyc, en, od);
        checks++;
        if (rd !== 32'h000000AD || cyc !== 4 || en !== 1 || od) begin
            failures++; $display("FAIL byte_read_b: got %h cycles=%0d en=%0d want 000000AD 4 1", rd, cyc, en);
        end
        access(1, 0, 2'b01, 10'h011, 32'h0, rd, cyc, en, od);
        checks++;
        if (rd !== 32'h0000ADBE || cyc !== 5 || en !== 2 || od) begin
            failures++; $display("FAIL half_read_b: got %h cycles=%0d en=%0d want 0000ADBE 5 2", rd, cyc, en);
        end
    endtask

    task automatic test_contention();
        bit exp_port [4];
        int ndone, run, guard;
        bit port;
        logic [31:0] rd, exp_rd;
        exp_port[0] = 0; exp_port[1] = 1; exp_port[2] = 0; exp_port[3] = 1;
        mem_model[10'h020] = 8'h01; mem_model[10'h021] = 8'h02;
        mem_model[10'h022] = 8'h03; mem_model[10'h023] = 8'h04;
        ndone = 0; run = 0; guard = 0;
        @(negedge clk);
        a_req = 1; a_we = 0; a_size = 2'b10; a_addr = 10'h010;
        b_req = 1; b_we = 0; b_size = 2'b10; b_addr = 10'h020;
        while (ndone < 4 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
            if (a_done && b_done) begin
                checks++; failures++; $display("FAIL contention_both_done: both done at step %0d", guard);
            end
            if (mem_en) run++;
            else if (run != 0) begin
                checks++;
                if (run !== 4) begin
                    failures++; $display("FAIL contention_burst_len: got %0d want 4", run);
                end
                run = 0;
            end
            if (a_done || b_done) begin
                port = b_done;
                rd = port ? b_rdata : a_rdata;
                exp_rd = exp_port[ndone] ? 32'h04030201 : 32'hDEADBEEF;
                checks++;
                if (port !== exp_port[ndone] || rd !== exp_rd) begin
                    failures++;
                    $display("FAIL contention_order[%0d]: port=%0d rdata=%h want port=%0d rdata=%h",
                             ndone, port, rd, exp_port[ndone], exp_rd);
                end
                ndone++;
                if (ndone == 4) begin a_req = 0; b_req = 0; end
            end
        end
        checks++;
        if (ndone !== 4) begin
            failures++; $display("FAIL contention_timeout: got %0d dones want 4", ndone);
        end
        repeat (4) begin
            @(posedge clk); #1;
            checks++;
            if (a_done || b_done || mem_en) begin
                failures++; $display("FAIL contention_quiet: a_done=%b b_done=%b mem_en=%b want 0", a_done, b_done, mem_en);
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] rd;
        int cyc, en;
        bit od;
        access(1, 1, 2'b10, 10'h3FE, 32'h11223344, rd, cyc, en, od);
        checks++;
        if (mem_model[10'h3FE] !== 8'h44 || mem_model[10'h3FF] !== 8'h33 ||
            mem_model[10'h000] !== 8'h22 || mem_model[10'h001] !== 8'h11) begin
            failures++;
            $display("FAIL wrap_bytes: got %h %h %h %h want 44 33 22 11",
                     mem_model[10'h3FE], mem_model[10'h3FF], mem_model[10'h000], mem_model[10'h001]);
        end
        access(0, 0, 2'b10, 10'h3FE, 32'h0, rd, cyc, en, od);
        checks++;
        if (rd !== 32'h11223344 || cyc !== 7) begin
            failures++; $display("FAIL wrap_read: got %h in %0d cycles want 11223344 in 7", rd, cyc);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        int cyc, en;
        bit od, done_seen;
        for (int i = 0; i < 4; i++) mem_model[10'h100 + i] = 8'h55;
        @(negedge clk);
        a_req = 1; a_we = 1; a_size = 2'b10; a_addr = 10'h100; a_wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        a_req = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (mem_addr !== 10'h102 || mem_en !== 1'b1) begin
            failures++; $display("FAIL mid_beat2: addr=%h en=%b want 102 1", mem_addr, mem_en);
        end
        rst = 0;
        #1;
        checks++;
        if (dbg_state !== 2'd0 || mem_en !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 10'h0 || mem_wdata !== 8'h0) begin
            failures++;
            $display("FAIL mid_async_reset: st=%0d en=%b we=%b addr=%h wd=%h want all 0",
                     dbg_state, mem_en, mem_we, mem_addr, mem_wdata);
        end
        done_seen = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (a_done || b_done) done_seen = 1;
        end
        @(negedge clk);
        rst = 1;
        repeat (6) begin
            @(posedge clk); #1;
            if (a_done || b_done) done_seen = 1;
        end
        checks++;
        if (done_seen) begin
            failures++; $display("FAIL mid_no_done: got a done want none");
        end
        checks++;
        if ({mem_model[10'h103], mem_model[10'h102], mem_model[10'h101], mem_model[10'h100]} !== 32'h5555F00D) begin
            failures++;
            $display("FAIL mid_partial_bytes: got %h%h%h%h want 5555F00D",
                     mem_model[10'h103], mem_model[10'h102], mem_model[10'h101], mem_model[10'h100]);
        end
        access(0, 0, 2'b00, 10'h101, 32'h0, rd, cyc, en, od);
        checks++;
        if (rd !== 32'h000000F0 || cyc !== 4) begin
            failures++; $display("FAIL mid_recover: got %h in %0d cycles want 000000F0 in 4", rd, cyc);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem_model[i] = 8'h00;
        test_reset();
        test_word_a();
        test_sizes_b();
        test_contention();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
